// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sum_1.sv
// One-bit full-adder cell, reused as the slice of the serial adder.
module sum_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice processes one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_width(N);

  state_t         state_r;
  logic [N-1:0]   a_sh_r;
  logic [N-1:0]   b_sh_r;
  logic [N-1:0]   s_sh_r;
  logic           c_r;
  logic [CW-1:0]  cnt_r;
  logic           s_bit;
  logic           co_bit;
  logic           last;

  sum_1 u_slice (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (c_r),
    .s    (s_bit),
    .cout (co_bit)
  );

  assign last = (cnt_r == CW'(N - 1));

  // Sequencer, operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= {N{1'b0}};
      b_sh_r  <= {N{1'b0}};
      s_sh_r  <= {N{1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum     <= {N{1'b0}};
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            c_r     <= cin;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= ADD;
          end else begin
            busy    <= 1'b0;
          end
        end
        ADD: begin
          a_sh_r <= {1'b0, a_sh_r[N-1:1]};
          b_sh_r <= {1'b0, b_sh_r[N-1:1]};
          s_sh_r <= {s_bit, s_sh_r[N-1:1]};
          c_r    <= co_bit;
          cnt_r  <= cnt_r + CW'(1);
          // The final sum bit is merged straight into the result register
          if (last) begin
            sum     <= {s_bit, s_sh_r[N-1:1]};
            cout    <= co_bit;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= c_r ^ co_bit;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
